// File: rtl/key_event_scheduler_pkg.sv
// Shared definitions for the keyboard event scheduler.
//   evt_t       : FIFO entry layout {rpt, make, code}, 11 bits total
//   rpt_state_e : typematic repeat FSM states
package key_event_scheduler_pkg;

  localparam int KEY_CODE_W = 9;
  localparam int EVT_W      = KEY_CODE_W + 2;

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_e;

  typedef struct packed {
    logic                  rpt;   // auto-repeat event
    logic                  make;  // 1 = press/repeat, 0 = release
    logic [KEY_CODE_W-1:0] code;  // {extend, scancode}
  } evt_t;

endpackage

// File: rtl/kbd_event_fifo.sv
// Synchronous first-word-fall-through FIFO for key events.
//   clk, rst_n  : clock, synchronous active-low reset
//   flush       : synchronous empty (same effect as reset)
//   push, din   : write request / data (accepted when not full, or full with a pop)
//   pop         : advance head (ignored when empty)
//   dout        : head entry, forced to 0 while empty
//   count       : entries queued (0..DEPTH); full, empty flags
module kbd_event_fifo
  import key_event_scheduler_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3,
  parameter int W      = EVT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic [W-1:0]      din,
  output logic [W-1:0]      dout,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty
);

  logic [W-1:0]    mem_q [DEPTH];
  logic [ADDR_W:0] wr_q, rd_q;
  logic            do_push, do_pop;

  assign count   = wr_q - rd_q;
  assign empty   = (wr_q == rd_q);
  assign full    = (count == (ADDR_W+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem_q[rd_q[ADDR_W-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && !flush && do_push) mem_q[wr_q[ADDR_W-1:0]] <= din;
  end

endmodule

// File: rtl/key_event_scheduler.sv
// Turns PS/2 decoder key_valid pulses into queued make/break events and
// generates typematic repeat events for the most recently pressed key.
//   clk, rst_n          : clock, synchronous active-low reset
//   key_valid           : decoder pulse; last_change/key_down updated this cycle
//   last_change[8:0]    : {extend, scancode} of the change
//   key_down[511:0]     : held-key bitmap
//   clear               : synchronous flush of FIFO, overflow and repeat FSM
//   evt_valid/evt_ready : head-event handshake
//   evt_code/make/repeat: head event fields
//   evt_count           : entries queued
//   overflow            : sticky, an event was dropped on a full FIFO
module key_event_scheduler
  import key_event_scheduler_pkg::*;
#(
  parameter int DEPTH         = 8,
  parameter int ADDR_W        = 3,
  parameter int REPEAT_DELAY  = 50_000_000,
  parameter int REPEAT_PERIOD = 10_000_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  key_valid,
  input  logic [KEY_CODE_W-1:0] last_change,
  input  logic [511:0]          key_down,
  input  logic                  clear,
  output logic                  evt_valid,
  input  logic                  evt_ready,
  output logic [KEY_CODE_W-1:0] evt_code,
  output logic                  evt_make,
  output logic                  evt_repeat,
  output logic [ADDR_W:0]       evt_count,
  output logic                  overflow
);

  localparam logic [31:0] DLY_LAST = 32'(REPEAT_DELAY - 1);
  localparam logic [31:0] PER_LAST = 32'(REPEAT_PERIOD - 1);

  rpt_state_e            state_q, state_d;
  logic [31:0]           cnt_q, cnt_d;
  logic [KEY_CODE_W-1:0] code_q, code_d;
  logic                  ovf_q, ovf_d;
  logic                  tick, key_make, held;
  logic                  push, fifo_full, fifo_empty;
  evt_t                  push_evt, head;

  assign key_make = key_down[last_change];
  assign held     = key_down[code_q];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    tick    = 1'b0;
    case (state_q)
      RPT_IDLE: begin end
      // Release is checked before the tick so no repeat follows a key-up.
      RPT_DELAY: begin
        if (!held) begin
          state_d = RPT_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DLY_LAST) begin
          tick    = 1'b1;
          cnt_d   = '0;
          state_d = RPT_REPEAT;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      RPT_REPEAT: begin
        if (!held) begin
          state_d = RPT_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == PER_LAST) begin
          tick  = 1'b1;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: begin
        state_d = RPT_IDLE;
        cnt_d   = '0;
      end
    endcase
    // Any new press retargets the repeat to that key and restarts the delay.
    if (key_valid && key_make) begin
      code_d  = last_change;
      cnt_d   = '0;
      state_d = RPT_DELAY;
    end
  end

  // Key events win the single push slot; a coincident tick is simply lost.
  assign push     = !clear && (key_valid || tick);
  assign push_evt = key_valid ? evt_t'{rpt: 1'b0, make: key_make, code: last_change}
                              : evt_t'{rpt: 1'b1, make: 1'b1,     code: code_q};
  // Full implies valid, so a drop happens exactly when the consumer is not taking the head.
  assign ovf_d    = ovf_q | (push && fifo_full && !evt_ready);

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      state_q <= RPT_IDLE;
      cnt_q   <= '0;
      code_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      ovf_q   <= ovf_d;
    end
  end

  kbd_event_fifo #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .W     (EVT_W)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .flush(clear),
    .push (push),
    .pop  (evt_ready),
    .din  (push_evt),
    .dout (head),
    .count(evt_count),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign evt_valid  = !fifo_empty;
  assign evt_code   = head.code;
  assign evt_make   = head.make;
  assign evt_repeat = head.rpt;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_key_event_scheduler.sv
module tb_key_event_scheduler;

  localparam int DEPTH = 4, ADDR_W = 2, RD = 20, RP = 5;

  logic         clk, rst_n, key_valid, clear, evt_ready;
  logic [8:0]   last_change;
  logic [511:0] key_down;
  logic         evt_valid, evt_make, evt_repeat, overflow;
  logic [8:0]   evt_code;
  logic [ADDR_W:0] evt_count;

  key_event_scheduler #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .last_change(last_change),
    .key_down(key_down), .clear(clear), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_code(evt_code), .evt_make(evt_make), .evt_repeat(evt_repeat),
    .evt_count(evt_count), .overflow(overflow)
  );

  typedef struct {
    logic       rpt;
    logic       make;
    logic [8:0] code;
    int         cyc;   // cycle the event must be on the outputs, -1 = untimed
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   cyc = 0;
  int   checks = 0, fails = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every accepted head event is matched against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && evt_valid && evt_ready) begin
      checks++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_evt got code=%h make=%b rpt=%b at cyc=%0d",
                 evt_code, evt_make, evt_repeat, cyc);
      end else begin
        e = sb.pop_front();
        if (evt_code !== e.code || evt_make !== e.make || evt_repeat !== e.rpt ||
            (e.cyc >= 0 && e.cyc != cyc)) begin
          fails++;
          $display("FAIL evt got code=%h make=%b rpt=%b cyc=%0d exp code=%h make=%b rpt=%b cyc=%0d",
                   evt_code, evt_make, evt_repeat, cyc, e.code, e.make, e.rpt, e.cyc);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) step();
  endtask

  task automatic push_exp(input logic rpt, input logic make, input logic [8:0] code, input int c);
    exp_t x;
    x.rpt = rpt; x.make = make; x.code = code; x.cyc = c;
    sb.push_back(x);
  endtask

  // Decoder model: one key_valid pulse; mk = cycle the event becomes visible.
  task automatic key_evt(input logic [8:0] code, input logic down, input bit expect_it,
                         input bit timed, output int mk);
    key_down[code] = down;
    last_change    = code;
    key_valid      = 1'b1;
    mk             = cyc + 1;
    if (expect_it) push_exp(1'b0, down, code, timed ? mk : -1);
    step();
    key_valid = 1'b0;
  endtask

  int m, m2, d;

  initial begin
    rst_n = 1'b0; key_valid = 1'b0; clear = 1'b0; evt_ready = 1'b0;
    last_change = '0; key_down = '0;
    repeat (3) step();
    rst_n = 1'b1;

    // Reset state
    chk("rst_valid",  32'(evt_valid),  0);
    chk("rst_code",   32'(evt_code),   0);
    chk("rst_make",   32'(evt_make),   0);
    chk("rst_repeat", 32'(evt_repeat), 0);
    chk("rst_count",  32'(evt_count),  0);
    chk("rst_ovf",    32'(overflow),   0);

    // 1: press/release 'A', drained afterwards
    key_evt(9'h01C, 1'b1, 1, 0, m);
    chk("t1_count1", 32'(evt_count), 1);
    chk("t1_valid",  32'(evt_valid), 1);
    chk("t1_code",   32'(evt_code),  32'h01C);
    chk("t1_make",   32'(evt_make),  1);
    key_evt(9'h01C, 1'b0, 1, 0, m);
    chk("t1_count2", 32'(evt_count), 2);
    evt_ready = 1'b1;
    step(); step();
    chk("t1_count0", 32'(evt_count), 0);

    // 2: hold 'A', repeats at +20,+25,+30,+35, release at +37
    key_evt(9'h01C, 1'b1, 1, 1, m);
    for (int i = 0; i < 4; i++) push_exp(1'b1, 1'b1, 9'h01C, m + RD + i*RP);
    wait_cyc(m + 36);
    key_evt(9'h01C, 1'b0, 1, 1, d);
    wait_cyc(m + 55);

    // 3: overflow with consumer stalled, then push+pop while full
    evt_ready = 1'b0;
    for (int i = 0; i < 5; i++) key_evt(9'h021 + 9'(i), 1'b0, i < 4, 0, d);
    chk("t3_count_full", 32'(evt_count), 4);
    chk("t3_ovf",        32'(overflow),  1);
    chk("t3_head",       32'(evt_code),  32'h021);
    evt_ready = 1'b1;
    key_evt(9'h026, 1'b0, 1, 0, d);
    chk("t3_count_pushpop", 32'(evt_count), 4);
    chk("t3_ovf_hold",      32'(overflow),  1);
    repeat (6) step();
    chk("t3_drained",   32'(evt_count), 0);
    chk("t3_ovf_stick", 32'(overflow),  1);
    clear = 1'b1; step(); clear = 1'b0;
    chk("t3_ovf_clear", 32'(overflow), 0);

    // 4: repeat retargets to the latest press; releasing the older key is ignored
    key_evt(9'h01C, 1'b1, 1, 1, m);
    wait_cyc(m + 9);
    key_evt(9'h11D, 1'b1, 1, 1, m2);
    wait_cyc(m2 + 2);
    key_evt(9'h01C, 1'b0, 1, 1, d);
    for (int i = 0; i < 3; i++) push_exp(1'b1, 1'b1, 9'h11D, m2 + RD + i*RP);
    wait_cyc(m2 + 31);
    key_evt(9'h11D, 1'b0, 1, 1, d);
    wait_cyc(m2 + 50);

    // 5: key event coincident with a repeat tick drops the tick
    key_evt(9'h015, 1'b1, 1, 1, m);
    push_exp(1'b1, 1'b1, 9'h015, m + RD);
    push_exp(1'b1, 1'b1, 9'h015, m + RD + RP);
    wait_cyc(m + RD + 2*RP - 1);
    key_evt(9'h033, 1'b0, 1, 1, d);
    chk("t5_coincide_cyc", 32'(d), 32'(m + RD + 2*RP));
    push_exp(1'b1, 1'b1, 9'h015, m + RD + 3*RP);
    wait_cyc(m + 36);
    key_evt(9'h015, 1'b0, 1, 1, d);
    wait_cyc(m + 50);

    // 6a: clear mid-DELAY with 3 queued (key_valid in the clear cycle discarded)
    evt_ready = 1'b0;
    key_evt(9'h016, 1'b1, 0, 0, m);
    key_evt(9'h040, 1'b0, 0, 0, d);
    key_evt(9'h041, 1'b0, 0, 0, d);
    chk("t6_count3", 32'(evt_count), 3);
    wait_cyc(m + 6);
    clear = 1'b1; key_valid = 1'b1; last_change = 9'h042;
    step();
    clear = 1'b0; key_valid = 1'b0;
    chk("t6c_valid", 32'(evt_valid), 0);
    chk("t6c_count", 32'(evt_count), 0);
    chk("t6c_ovf",   32'(overflow),  0);
    evt_ready = 1'b1;
    repeat (30) step();

    // 6b: same with reset
    evt_ready = 1'b0;
    key_evt(9'h017, 1'b1, 0, 0, m);
    key_evt(9'h043, 1'b0, 0, 0, d);
    key_evt(9'h044, 1'b0, 0, 0, d);
    chk("t6r_count3", 32'(evt_count), 3);
    wait_cyc(m + 6);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("t6r_valid", 32'(evt_valid), 0);
    chk("t6r_count", 32'(evt_count), 0);
    chk("t6r_ovf",   32'(overflow),  0);
    evt_ready = 1'b1;
    repeat (30) step();

    chk("sb_empty", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
